// File: rtl/burst_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : burst_memory_pkg
// Brief    : Shared types, defaults and address-wrap helper for burst_memory.
// Revision : 1.0 - initial release
// ============================================================================
package burst_memory_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBURST = 2'd1,
        RBURST = 2'd2
    } state_t;

    localparam int c_DEF_WIDTH      = 32;
    localparam int c_DEF_DEPTH      = 16;
    localparam int c_DEF_ADDR_WIDTH = 4;
    localparam int c_DEF_LEN_WIDTH  = 4;
    localparam int c_DEF_RD_LAT     = 1;
    localparam int c_DEF_CLEAR      = 1;

    // Incrementing word address that wraps from depth-1 back to 0.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input int unsigned depth);
        return (addr >= depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/burst_memory_rdpipe.sv
`default_nettype none
// ============================================================================
// Module   : burst_memory_rdpipe
// Brief    : RD_LAT-stage {valid, data} delay line; data holds when not valid.
// Revision : 1.0 - initial release
// ============================================================================
module burst_memory_rdpipe #(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    for (genvar j = 0; j < RD_LAT; j++) begin : g_stage
        logic             w_in_vld;
        logic [WIDTH-1:0] w_in_dat;
        logic             r_vld;
        logic [WIDTH-1:0] r_dat;

        if (j == 0) begin : g_first
            assign w_in_vld = in_valid;
            assign w_in_dat = in_data;
        end else begin : g_next
            assign w_in_vld = g_stage[j-1].r_vld;
            assign w_in_dat = g_stage[j-1].r_dat;
        end

        // Data only advances with a valid beat so the last stage holds rdata.
        always_ff @(posedge clk) begin
            if (res) begin
                r_vld <= 1'b0;
                r_dat <= '0;
            end else begin
                r_vld <= w_in_vld;
                if (w_in_vld) begin
                    r_dat <= w_in_dat;
                end
            end
        end
    end

    assign out_valid = g_stage[RD_LAT-1].r_vld;
    assign out_data  = g_stage[RD_LAT-1].r_dat;

endmodule
`default_nettype wire

// File: rtl/burst_memory.sv
`default_nettype none
// ============================================================================
// Module   : burst_memory
// Brief    : Single-port burst memory with byte strobes, wrap and read latency.
// Revision : 1.0 - initial release
// ============================================================================
module burst_memory
    import burst_memory_pkg::*;
#(
    parameter int WIDTH          = c_DEF_WIDTH,
    parameter int DEPTH          = c_DEF_DEPTH,
    parameter int ADDR_WIDTH     = c_DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH      = c_DEF_LEN_WIDTH,
    parameter int RD_LAT         = c_DEF_RD_LAT,
    parameter int CLEAR_ON_RESET = c_DEF_CLEAR
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  err
);

    localparam int                  c_BYTES = WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic                  r_ready;
    logic                  r_err;

    logic                  w_fire;
    logic                  w_in_range;
    logic                  w_issue;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [WIDTH-1:0]      w_rd_word;

    assign w_fire      = valid && r_ready;
    assign w_in_range  = ({1'b0, addr} < c_DEPTH);
    assign w_next_addr = ADDR_WIDTH'(next_addr(32'(w_acc_addr), DEPTH));
    assign w_rd_word   = r_mem[w_acc_addr];

    // Single access port: a write, a read issue, or nothing, at w_acc_addr.
    always_comb begin
        w_issue    = 1'b0;
        w_wr       = 1'b0;
        w_acc_addr = r_addr;
        case (r_state)
            IDLE: begin
                w_acc_addr = addr;
                if (w_fire && w_in_range) begin
                    w_wr    = wr_rd;
                    w_issue = !wr_rd;
                end
            end
            WBURST:  w_wr    = w_fire;
            RBURST:  w_issue = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_rem   <= '0;
        end else begin
            r_ready <= 1'b1;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        if (!w_in_range) begin
                            r_err <= 1'b1;
                        end else begin
                            r_addr <= w_next_addr;
                            r_rem  <= len;
                            if (len != '0) begin
                                r_state <= wr_rd ? WBURST : RBURST;
                                if (!wr_rd) begin
                                    r_ready <= 1'b0;
                                end
                            end
                        end
                    end
                end
                WBURST: begin
                    if (w_fire) begin
                        r_addr <= w_next_addr;
                        r_rem  <= r_rem - LEN_WIDTH'(1);
                        if (r_rem == LEN_WIDTH'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                RBURST: begin
                    r_addr <= w_next_addr;
                    r_rem  <= r_rem - LEN_WIDTH'(1);
                    if (r_rem == LEN_WIDTH'(1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_ready <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            if (CLEAR_ON_RESET != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
            end
        end else if (w_wr) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (wstrb[b]) begin
                    r_mem[w_acc_addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Array is sampled at the issue edge; later writes cannot alter the beat.
    burst_memory_rdpipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk       (clk),
        .res       (res),
        .in_valid  (w_issue),
        .in_data   (w_rd_word),
        .out_valid (rvalid),
        .out_data  (rdata)
    );

    assign ready = r_ready;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_burst_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_memory
// Brief    : Directed scoreboard bench for burst_memory (DEPTH=12, RD_LAT=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_memory;

    localparam int c_W  = 32;
    localparam int c_D  = 12;
    localparam int c_AW = 4;
    localparam int c_LW = 4;
    localparam int c_RL = 2;

    logic            clk = 1'b0;
    logic            res = 1'b1;
    logic            valid = 1'b0;
    logic            ready;
    logic            wr_rd = 1'b0;
    logic [c_AW-1:0] addr = '0;
    logic [c_LW-1:0] len = '0;
    logic [c_W-1:0]  wdata = '0;
    logic [3:0]      wstrb = '0;
    logic [c_W-1:0]  rdata;
    logic            rvalid;
    logic            err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t q[$];

    burst_memory #(
        .WIDTH(c_W), .DEPTH(c_D), .ADDR_WIDTH(c_AW), .LEN_WIDTH(c_LW),
        .RD_LAT(c_RL), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .res(res), .valid(valid), .ready(ready), .wr_rd(wr_rd),
        .addr(addr), .len(len), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .rvalid(rvalid), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every rvalid beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (rvalid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: got rdata %h at cycle %0d, want no beat", rdata, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (rdata !== e.d || cyc != e.c) begin
                    errors++;
                    $display("FAIL read_beat: got %h at cycle %0d, want %h at cycle %0d", rdata, cyc, e.d, e.c);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Present one beat; returns the edge number at which it was accepted.
    task automatic send(input logic w, input logic [3:0] a, input logic [3:0] l,
                        input logic [31:0] d, input logic [3:0] s, output int k);
        int n = 0;
        valid = 1'b1; wr_rd = w; addr = a; len = l; wdata = d; wstrb = s;
        while (!ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: got ready=0 after %0d cycles, want 1", n);
        end
        @(posedge clk); #1;
        k = cyc;
        valid = 1'b0;
    endtask

    task automatic expect_beat(input logic [31:0] d, input int c);
        exp_t e;
        e.d = d; e.c = c;
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending, want 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int k;
        logic [31:0] wrap_data [4];
        wrap_data[0] = 32'hA0; wrap_data[1] = 32'hA1;
        wrap_data[2] = 32'hA2; wrap_data[3] = 32'hA3;

        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_ready", {31'd0, ready}, 32'd0);
            chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
            chk("reset_err", {31'd0, err}, 32'd0);
        end
        res = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", {31'd0, ready}, 32'd1);
        chk("rdata_after_reset", rdata, 32'd0);

        send(1'b0, 4'd5, 4'd0, 32'd0, 4'd0, k);
        expect_beat(32'h0000_0000, k + 1);
        drain();

        // Single write then read; read issued on the very next edge.
        send(1'b1, 4'd3, 4'd0, 32'hDEADBEEF, 4'b1111, k);
        send(1'b0, 4'd3, 4'd0, 32'd0, 4'd0, k);
        expect_beat(32'hDEADBEEF, k + 1);
        drain();

        // Byte strobes 0101 update bytes 0 and 2 only.
        send(1'b1, 4'd3, 4'd0, 32'h11223344, 4'b0101, k);
        send(1'b0, 4'd3, 4'd0, 32'd0, 4'd0, k);
        expect_beat(32'hDE22BE44, k + 1);
        drain();

        // Wrapping write burst 10, 11, 0, 1.
        for (int i = 0; i < 4; i++) begin
            send(1'b1, (i == 0) ? 4'd10 : 4'd7, 4'd3, wrap_data[i], 4'b1111, k);
        end
        send(1'b0, 4'd10, 4'd3, 32'd0, 4'd0, k);
        for (int i = 0; i < 4; i++) expect_beat(wrap_data[i], k + 1 + i);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("burst_occupancy_ready", {31'd0, ready}, (i < 3) ? 32'd0 : 32'd1);
        end
        drain();

        send(1'b0, 4'd0, 4'd1, 32'd0, 4'd0, k);
        expect_beat(32'hA2, k + 1);
        expect_beat(32'hA3, k + 2);
        drain();

        // Out-of-range read, followed immediately by a valid read.
        send(1'b0, 4'd13, 4'd0, 32'd0, 4'd0, k);
        chk("oor_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        chk("oor_err_pulse", {31'd0, err}, 32'd1);
        send(1'b0, 4'd3, 4'd0, 32'd0, 4'd0, k);
        expect_beat(32'hDE22BE44, k + 1);
        @(negedge clk);
        chk("oor_err_single", {31'd0, err}, 32'd0);
        drain();

        // Reset during the second beat of an 8-beat read.
        send(1'b0, 4'd10, 4'd7, 32'd0, 4'd0, k);
        expect_beat(32'hA0, k + 1);
        expect_beat(32'hA1, k + 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        res = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midreset_rvalid", {31'd0, rvalid}, 32'd0);
        @(posedge clk); #1;
        res = 1'b0;
        @(posedge clk); #1;
        chk("midreset_idle_ready", {31'd0, ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midreset_no_stale", {31'd0, rvalid}, 32'd0);
        end
        chk("midreset_queue_empty", q.size(), 32'd0);

        // Memory was cleared by the mid-burst reset.
        @(posedge clk); #1;
        send(1'b0, 4'd10, 4'd0, 32'd0, 4'd0, k);
        expect_beat(32'h0, k + 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
